code_sequencer: RTL and testbench
=================================

// Module: code_sequencer
// PURPOSE
//   Produces a descending stream of selector codes, START_CODE down to 0, on a
//   valid/ready interface. One code is emitted per accepted beat.
//   Feeds the downstream display/decode stage, whose if/case/casez/casex
//   branches select on the code value. Also drives a registered one-hot copy of
//   the code, built with a generate-for, so each downstream lane sees one bit.
// PARAMETERS
//   CODE_W      3   width of code; must satisfy 2**CODE_W > START_CODE
//   START_CODE  5   first code emitted; the sequence is START_CODE..0
// PORTS
//   clk          in   1               rising-edge clock
//   rst_n        in   1               asynchronous, active-low reset
//   start        in   1               start request; sampled in IDLE only
//   code_ready   in   1               downstream accepts the current code
//   code_valid   out  1               code is valid
//   code         out  CODE_W          current selector code
//   code_onehot  out  START_CODE+1    bit[code] set while code_valid, else all 0
//   busy         out  1               1 in RUN or DONE
//   done         out  1               one-cycle pulse after the code-0 beat is accepted
// BEHAVIOUR
//   - Reset (rst_n=0, async): state=IDLE; code_valid=0, code=0, code_onehot=0,
//     busy=0, done=0. All outputs are registered.
//   - FSM states: IDLE, RUN, DONE.
//     IDLE->RUN on start=1. Next cycle: code=START_CODE, code_valid=1,
//       busy=1, code_onehot[START_CODE]=1.
//     RUN: a transfer occurs when code_valid & code_ready.
//       Transfer with code>0: code <= code-1 on the next edge; code_valid stays 1.
//       Transfer with code==0: RUN->DONE; code_valid=0, code_onehot=0, done=1.
//       No transfer (code_ready=0): code, code_valid and code_onehot hold.
//     DONE->IDLE unconditionally after 1 cycle; done=0, busy=0.
//   - Latency: start to first valid is 1 cycle. Full-rate ready gives one code
//     per cycle, so START_CODE+1 beats in total.
//   - start is ignored in RUN and DONE, including start in the DONE cycle.
//     A start in the first IDLE cycle after DONE is accepted.
//   - Reset mid-RUN aborts the sequence: no done pulse; outputs take reset values.
//   - code never wraps. There is no decrement below 0; code==0 ends the sequence.
//   - code_onehot is updated on the same edge as code:
//     generate-for i in 0..START_CODE, code_onehot[i] <= next_valid & (next_code==i).
//   - Invariant: code_valid == |code_onehot, and $onehot0(code_onehot) always.
//   - code_ready while code_valid=0 has no effect.
// TESTING
//   1 Reset, start=1 for 1 cycle, code_ready=1 -> codes 5,4,3,2,1,0 on 6 cycles;
//     done=1 exactly 1 cycle later; busy low 2 cycles after the last beat.
//   2 code_ready low for 3 cycles while code=3 -> code=3, code_onehot=6'b001000
//     held all 3 cycles; 2 follows after ready rises.
//   3 start=1 held throughout RUN and DONE -> one sequence only; a new sequence
//     starts from the first IDLE cycle after DONE.
//   4 rst_n=0 asynchronously mid-cycle while code=2 -> outputs 0 before the next
//     edge; no done pulse; next start restarts at 5.
//   5 Random code_ready (50%) for 200 runs -> exact sequence 5..0 each run;
//     onehot invariant holds; done count == run count.
//   6 CODE_W=4, START_CODE=12 -> 13 beats 12..0; code_onehot width 13.

Source files
------------

// File: rtl/code_sequencer.sv
// ----------------------------------------------------------------------------
// code_sequencer
//   Emits a descending stream of selector codes START_CODE..0 on a valid/ready
//   interface, one code per accepted beat, plus a registered one-hot copy of
//   the current code so each downstream decode lane sees a single bit.
//
// Parameters
//   CODE_W      width of code; 2**CODE_W must exceed START_CODE
//   START_CODE  first code emitted; the sequence is START_CODE down to 0
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   start        in   start request, sampled only while idle
//   code_ready   in   downstream accepts the current code
//   code_valid   out  code is valid
//   code         out  current selector code
//   code_onehot  out  bit[code] set while code_valid, otherwise all zero
//   busy         out  high while a sequence is running or finishing
//   done         out  one-cycle pulse after the code-0 beat is accepted
//
// All outputs are registered. The output-comb process computes the values
// each output register loads on the next edge.
// ----------------------------------------------------------------------------
module code_sequencer #(
    parameter int CODE_W     = 3,
    parameter int START_CODE = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                code_ready,
    output logic                code_valid,
    output logic [CODE_W-1:0]   code,
    output logic [START_CODE:0] code_onehot,
    output logic                busy,
    output logic                done
);

    // Guard against a code width too narrow to hold START_CODE.
    if ((2 ** CODE_W) <= START_CODE) begin : g_bad_width
        $error("code_sequencer: CODE_W too small for START_CODE");
    end

    localparam logic [CODE_W-1:0] FIRST_CODE = CODE_W'(START_CODE);
    localparam logic [CODE_W-1:0] CODE_ONE   = CODE_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t              state;
    state_t              next_state;

    logic                next_valid;
    logic [CODE_W-1:0]   next_code;
    logic                next_busy;
    logic                next_done;
    logic                xfer;

    // A beat transfers only when the code is actually presented.
    assign xfer = code_valid & code_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (xfer && (code == '0)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                // start is deliberately ignored here.
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: values loaded into the output registers on next edge
    // ------------------------------------------------------------------
    always_comb begin
        next_code  = code;
        next_valid = code_valid;
        next_done  = 1'b0;
        // busy covers RUN and DONE, so it follows the state being entered.
        next_busy  = (next_state != IDLE);
        unique case (state)
            IDLE: begin
                if (start) begin
                    next_code  = FIRST_CODE;
                    next_valid = 1'b1;
                end else begin
                    next_code  = '0;
                    next_valid = 1'b0;
                end
            end
            RUN: begin
                if (xfer) begin
                    if (code != '0) begin
                        next_code = code - CODE_ONE;
                    end else begin
                        // Last beat taken: code stays at 0, never wraps.
                        next_valid = 1'b0;
                        next_done  = 1'b1;
                    end
                end
            end
            DONE: begin
                next_code  = '0;
                next_valid = 1'b0;
            end
            default: begin
                next_code  = '0;
                next_valid = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_valid <= 1'b0;
            code       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            code_valid <= next_valid;
            code       <= next_code;
            busy       <= next_busy;
            done       <= next_done;
        end
    end

    // One-hot lanes are decoded from the next-cycle code so they change on
    // the same edge as code and stay all-zero whenever code_valid is low.
    for (genvar i = 0; i <= START_CODE; i++) begin : g_onehot
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                code_onehot[i] <= 1'b0;
            end else begin
                code_onehot[i] <= next_valid && (next_code == CODE_W'(i));
            end
        end
    end

endmodule

// File: tb/tb_code_sequencer.sv
module tb_code_sequencer;

    localparam int CW   = 3;
    localparam int SC   = 5;
    localparam int CW12 = 4;
    localparam int SC12 = 12;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            code_ready = 1'b0;
    logic            code_valid;
    logic [CW-1:0]   code;
    logic [SC:0]     code_onehot;
    logic            busy;
    logic            done;

    logic            start12 = 1'b0;
    logic            ready12 = 1'b1;
    logic            valid12;
    logic [CW12-1:0] code12;
    logic [SC12:0]   onehot12;
    logic            busy12;
    logic            done12;

    int total = 0;
    int bad   = 0;

    // Scoreboard state
    int   exp_q[$];
    logic done_exp = 1'b0;
    int   dut_dones = 0;
    int   runs_accepted = 0;

    always #5 clk = ~clk;

    code_sequencer #(.CODE_W(CW), .START_CODE(SC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .code_ready  (code_ready),
        .code_valid  (code_valid),
        .code        (code),
        .code_onehot (code_onehot),
        .busy        (busy),
        .done        (done)
    );

    code_sequencer #(.CODE_W(CW12), .START_CODE(SC12)) dut12 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start12),
        .code_ready  (ready12),
        .code_valid  (valid12),
        .code        (code12),
        .code_onehot (onehot12),
        .busy        (busy12),
        .done        (done12)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: samples on the falling edge, where the inputs seen are the
    // ones the next rising edge will use.
    always @(negedge clk) begin
        logic         ev;
        logic         nxt_done;
        logic [SC:0]  exp_oh;
        int           e;
        if (!rst_n) begin
            chk("rst_valid",  code_valid, 0);
            chk("rst_code",   code, 0);
            chk("rst_onehot", code_onehot, 0);
            chk("rst_busy",   busy, 0);
            chk("rst_done",   done, 0);
            exp_q.delete();
            done_exp = 1'b0;
        end else begin
            ev = (exp_q.size() > 0);
            chk("valid", code_valid, ev);
            chk("done",  done, done_exp);
            chk("busy",  busy, ev || done_exp);
            chk("onehot_inv", (code_valid == (|code_onehot)) && $onehot0(code_onehot), 1);
            if (done) dut_dones++;
            nxt_done = 1'b0;
            if (ev) begin
                e = exp_q[0];
                exp_oh = '0;
                exp_oh[e] = 1'b1;
                chk("code",   code, e);
                chk("onehot", code_onehot, exp_oh);
                if (code_ready) begin
                    void'(exp_q.pop_front());
                    if (e == 0) nxt_done = 1'b1;
                end
            end
            // Idle per the model: nothing left to emit and not in the done cycle.
            if (!ev && !done_exp && start) begin
                for (int c = SC; c >= 0; c--) exp_q.push_back(c);
                runs_accepted++;
            end
            done_exp = nxt_done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || code_valid) && n < 200) begin
            tick();
            n++;
        end
        chk(name, busy, 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d0;
        int r0;
        logic [SC12:0] oh;

        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // 1: full-rate sequence
        code_ready = 1'b1;
        pulse_start();
        for (int k = SC; k >= 0; k--) begin
            chk("t1_code", code, k);
            tick();
        end
        chk("t1_done", done, 1);
        tick();
        chk("t1_busy_low", busy, 0);
        wait_idle("t1_idle");

        // 2: stall while code=3
        pulse_start();
        n = 0;
        while (code != 3 && n < 20) begin tick(); n++; end
        chk("t2_reach3", code, 3);
        code_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_hold_code", code, 3);
            chk("t2_hold_onehot", code_onehot, 6'b001000);
        end
        code_ready = 1'b1;
        tick();
        chk("t2_next", code, 2);
        wait_idle("t2_idle");

        // 3: start held through RUN and DONE
        d0 = dut_dones;
        r0 = runs_accepted;
        start = 1'b1;
        repeat (20) tick();
        start = 1'b0;
        wait_idle("t3_idle");
        repeat (2) tick();
        chk("t3_runs", runs_accepted - r0, (20 + SC + 2) / (SC + 3));
        chk("t3_dones", dut_dones - d0, runs_accepted - r0);

        // 4: asynchronous reset mid-run
        d0 = dut_dones;
        pulse_start();
        n = 0;
        while (code != 2 && n < 20) begin tick(); n++; end
        chk("t4_reach2", code, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_async_valid",  code_valid, 0);
        chk("t4_async_code",   code, 0);
        chk("t4_async_onehot", code_onehot, 0);
        chk("t4_async_busy",   busy, 0);
        chk("t4_async_done",   done, 0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("t4_no_done", dut_dones - d0, 0);
        pulse_start();
        chk("t4_restart", code, SC);
        wait_idle("t4_idle");

        // 5: random ready, 200 runs
        d0 = dut_dones;
        for (int run = 0; run < 200; run++) begin
            wait_idle("t5_idle");
            code_ready = 1'($urandom_range(0, 1));
            pulse_start();
            n = 0;
            while (!done && n < 200) begin
                code_ready = 1'($urandom_range(0, 1));
                tick();
                n++;
            end
            chk("t5_done_seen", done, 1);
        end
        code_ready = 1'b1;
        wait_idle("t5_final_idle");
        repeat (2) tick();
        chk("t5_dones", dut_dones - d0, 200);

        // 6: wider configuration
        chk("t6_idle_valid", valid12, 0);
        start12 = 1'b1;
        tick();
        start12 = 1'b0;
        for (int k = SC12; k >= 0; k--) begin
            chk("t6_valid", valid12, 1);
            chk("t6_code", code12, k);
            oh = '0;
            oh[k] = 1'b1;
            chk("t6_onehot", onehot12, oh);
            tick();
        end
        chk("t6_done", done12, 1);
        chk("t6_valid_end", valid12, 0);
        chk("t6_onehot_end", onehot12, 0);
        tick();
        chk("t6_busy_low", busy12, 0);
        chk("t6_done_low", done12, 0);

        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
